// File: rtl/clock_ctrl_pkg.sv
// Shared types, field codes and BCD helpers for the clock set controller.
// Imported by tick_gen and clock_set_controller.
package clock_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RUN,
        S_T_HH,
        S_T_MM,
        S_T_SS,
        S_T_LOAD,
        S_A_HH,
        S_A_MM,
        S_A_SS,
        S_A_PUT
    } state_t;

    typedef enum logic [1:0] {
        EF_NONE = 2'd0,
        EF_HH   = 2'd1,
        EF_MM   = 2'd2,
        EF_SS   = 2'd3
    } edit_field_t;

    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    // Any value at or past the limit wraps to 00, so stale input cannot escape the range
    function automatic logic [7:0] bcd_wrap_inc(input logic [7:0] v,
                                                input logic [7:0] max);
        if (v >= max) begin
            return 8'h00;
        end
        if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'h0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/clock_set_controller_tick_gen.sv
// Prescaler producing the one-cycle ena tick; hold parks the count at zero.
// While held, ena is suppressed even if the count was mid-period.
module tick_gen
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_hold,
    output logic o_ena
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign o_ena  = w_last && !i_hold;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_hold) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Button sequencer for Digital_Clock: time/alarm editing, load and
// put_alarm strobes, alarm stop (manual or timed) and the 1 Hz ena tick.
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV      = 100000000,
    parameter int ALARM_TIMEOUT = 60
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_ok,
    input  logic       i_btn_inc,
    input  logic [7:0] i_cur_hh,
    input  logic [7:0] i_cur_mm,
    input  logic [7:0] i_cur_ss,
    input  logic       i_alarm_in,
    output logic       o_ena,
    output logic [7:0] o_hh_in,
    output logic [7:0] o_mm_in,
    output logic [7:0] o_ss_in,
    output logic       o_load,
    output logic       o_put_alarm,
    output logic       o_stop_alarm,
    output logic [1:0] o_edit_field,
    output logic       o_setting_alarm
);

    localparam int TW = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ALARM_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_hh, r_mm, r_ss;
    logic [7:0]  w_hh_nxt, w_mm_nxt, w_ss_nxt;
    logic [7:0]  r_ahh, r_amm, r_ass;
    logic [TW-1:0] r_to_cnt;
    logic        r_stop, r_defer;
    logic        w_mode, w_ok, w_inc;
    logic        w_btn_stop, w_auto, w_stop_req, w_strobe_nxt;
    logic        w_hold;
    edit_field_t w_field;

    assign w_mode = i_btn_mode;
    assign w_ok   = i_btn_ok & ~i_btn_mode;
    assign w_inc  = i_btn_inc & ~i_btn_mode & ~i_btn_ok;

    assign w_hold = (r_state == S_T_HH) || (r_state == S_T_MM) ||
                    (r_state == S_T_SS) || (r_state == S_T_LOAD);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_hold (w_hold),
        .o_ena  (o_ena)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hh_nxt    = r_hh;
        w_mm_nxt    = r_mm;
        w_ss_nxt    = r_ss;
        w_btn_stop  = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (i_alarm_in) begin
                    w_btn_stop = w_mode | w_ok;
                end else if (w_mode) begin
                    w_state_nxt = S_T_HH;
                    w_hh_nxt    = i_cur_hh;
                    w_mm_nxt    = i_cur_mm;
                    w_ss_nxt    = i_cur_ss;
                end else if (w_ok) begin
                    w_state_nxt = S_A_HH;
                    w_hh_nxt    = r_ahh;
                    w_mm_nxt    = r_amm;
                    w_ss_nxt    = r_ass;
                end
            end
            S_T_HH, S_A_HH: begin
                if (w_mode) begin
                    w_state_nxt = S_RUN;
                end else if (w_ok) begin
                    w_state_nxt = (r_state == S_T_HH) ? S_T_MM : S_A_MM;
                end else if (w_inc) begin
                    w_hh_nxt = bcd_wrap_inc(r_hh, HH_MAX);
                end
            end
            S_T_MM, S_A_MM: begin
                if (w_mode) begin
                    w_state_nxt = S_RUN;
                end else if (w_ok) begin
                    w_state_nxt = (r_state == S_T_MM) ? S_T_SS : S_A_SS;
                end else if (w_inc) begin
                    w_mm_nxt = bcd_wrap_inc(r_mm, MS_MAX);
                end
            end
            S_T_SS, S_A_SS: begin
                if (w_mode) begin
                    w_state_nxt = S_RUN;
                end else if (w_ok) begin
                    w_state_nxt = (r_state == S_T_SS) ? S_T_LOAD : S_A_PUT;
                end else if (w_inc) begin
                    w_ss_nxt = bcd_wrap_inc(r_ss, MS_MAX);
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // A stop landing on a load/put cycle slips one cycle to keep strobes exclusive
    assign w_auto       = i_alarm_in && o_ena && (r_to_cnt == TO_LAST);
    assign w_stop_req   = w_auto | w_btn_stop | r_defer;
    assign w_strobe_nxt = (w_state_nxt == S_T_LOAD) || (w_state_nxt == S_A_PUT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_RUN;
            r_hh     <= 8'h00;
            r_mm     <= 8'h00;
            r_ss     <= 8'h00;
            r_ahh    <= 8'h00;
            r_amm    <= 8'h00;
            r_ass    <= 8'h00;
            r_to_cnt <= '0;
            r_stop   <= 1'b0;
            r_defer  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hh    <= w_hh_nxt;
            r_mm    <= w_mm_nxt;
            r_ss    <= w_ss_nxt;
            if (r_state == S_A_PUT) begin
                r_ahh <= r_hh;
                r_amm <= r_mm;
                r_ass <= r_ss;
            end
            if (!i_alarm_in || w_stop_req) begin
                r_to_cnt <= '0;
            end else if (o_ena) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            r_stop  <= w_stop_req && !w_strobe_nxt;
            r_defer <= w_stop_req && w_strobe_nxt;
        end
    end

    always_comb begin
        w_field = EF_NONE;
        unique case (r_state)
            S_T_HH, S_A_HH: w_field = EF_HH;
            S_T_MM, S_A_MM: w_field = EF_MM;
            S_T_SS, S_A_SS: w_field = EF_SS;
            default:        w_field = EF_NONE;
        endcase
    end

    assign o_edit_field    = w_field;
    assign o_hh_in         = r_hh;
    assign o_mm_in         = r_mm;
    assign o_ss_in         = r_ss;
    assign o_load          = (r_state == S_T_LOAD);
    assign o_put_alarm     = (r_state == S_A_PUT);
    assign o_stop_alarm    = r_stop;
    assign o_setting_alarm = (r_state == S_A_HH) || (r_state == S_A_MM) ||
                             (r_state == S_A_SS) || (r_state == S_A_PUT);

endmodule

// File: tb/tb_clock_set_controller.sv
// Randomised and directed bench for clock_set_controller against a
// decimal-arithmetic model of the editing and alarm rules.
module tb_clock_set_controller;

    localparam int TD = 10;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_btn_mode = 1'b0, i_btn_ok = 1'b0, i_btn_inc = 1'b0;
    logic [7:0] i_cur_hh = 8'h00, i_cur_mm = 8'h00, i_cur_ss = 8'h00;
    logic       i_alarm_in = 1'b0;
    logic       o_ena, o_load, o_put_alarm, o_stop_alarm, o_setting_alarm;
    logic [7:0] o_hh_in, o_mm_in, o_ss_in;
    logic [1:0] o_edit_field;
    logic [30:0] w_dut;

    int n_cmp = 0;
    int n_err = 0;

    // model: mode 0 run, 1 time edit, 2 time load, 3 alarm edit, 4 alarm put
    int m_mode, m_fld, m_cyc, m_base, m_ticks;
    int m_e[3], m_a[3];
    bit m_stop, m_defer;
    int cur_h, cur_m, cur_s;

    clock_set_controller #(
        .TICK_DIV(TD),
        .ALARM_TIMEOUT(TO)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_btn_mode(i_btn_mode),
        .i_btn_ok(i_btn_ok),
        .i_btn_inc(i_btn_inc),
        .i_cur_hh(i_cur_hh),
        .i_cur_mm(i_cur_mm),
        .i_cur_ss(i_cur_ss),
        .i_alarm_in(i_alarm_in),
        .o_ena(o_ena),
        .o_hh_in(o_hh_in),
        .o_mm_in(o_mm_in),
        .o_ss_in(o_ss_in),
        .o_load(o_load),
        .o_put_alarm(o_put_alarm),
        .o_stop_alarm(o_stop_alarm),
        .o_edit_field(o_edit_field),
        .o_setting_alarm(o_setting_alarm)
    );

    assign w_dut = {o_ena, o_load, o_put_alarm, o_stop_alarm, o_edit_field,
                    o_setting_alarm, o_hh_in, o_mm_in, o_ss_in};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic bit m_ena();
        if (m_mode == 1 || m_mode == 2) return 1'b0;
        return ((m_cyc - m_base) % TD) == TD - 1;
    endfunction

    function automatic logic [30:0] exp_vec();
        logic [1:0] f;
        f = (m_mode == 1 || m_mode == 3) ? 2'(m_fld) : 2'd0;
        return {m_ena(), m_mode == 2, m_mode == 4, m_stop, f, m_mode >= 3,
                bcd(m_e[0]), bcd(m_e[1]), bcd(m_e[2])};
    endfunction

    task automatic set_cur(input int h, input int m, input int s);
        cur_h = h; cur_m = m; cur_s = s;
        i_cur_hh = bcd(h); i_cur_mm = bcd(m); i_cur_ss = bcd(s);
    endtask

    task automatic model_edge(input bit md, input bit ok, input bit inc,
                              input bit alm);
        bit ena, req;
        int nm, lim;
        ena = m_ena();
        req = m_defer;
        nm = m_mode;
        if (m_mode == 1 || m_mode == 2) m_base = m_cyc + 1;
        case (m_mode)
            0: begin
                if (alm && (md || ok)) req = 1'b1;
                else if (md) begin nm = 1; m_fld = 1; m_e = '{cur_h, cur_m, cur_s}; end
                else if (ok) begin nm = 3; m_fld = 1; m_e = m_a; end
            end
            1, 3: begin
                if (md) nm = 0;
                else if (ok) begin
                    if (m_fld == 3) nm = m_mode + 1;
                    else m_fld++;
                end else if (inc) begin
                    lim = (m_fld == 1) ? 24 : 60;
                    m_e[m_fld-1] = (m_e[m_fld-1] + 1) % lim;
                end
            end
            2: nm = 0;
            default: begin m_a = m_e; nm = 0; end
        endcase
        if (!alm) m_ticks = 0;
        else if (ena) begin
            m_ticks++;
            if (m_ticks == TO) req = 1'b1;
        end
        if (req) m_ticks = 0;
        m_defer = req && (nm == 2 || nm == 4);
        m_stop = req && !(nm == 2 || nm == 4);
        m_mode = nm;
        m_cyc++;
    endtask

    task automatic tick(input bit md, input bit ok, input bit inc);
        i_btn_mode = md; i_btn_ok = ok; i_btn_inc = inc;
        model_edge(md, ok, inc, i_alarm_in);
        @(posedge clk);
        @(negedge clk);
        i_btn_mode = 1'b0; i_btn_ok = 1'b0; i_btn_inc = 1'b0;
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        repeat (n) begin
            m_mode = 0; m_fld = 1; m_ticks = 0; m_stop = 0; m_defer = 0;
            m_e = '{0, 0, 0}; m_a = '{0, 0, 0};
            m_base = m_cyc + 1;
            m_cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset(3);
        n_cmp++;
        if (w_dut !== 31'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", w_dut);
        end
        n_cmp++;
        if (w_dut !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_model: got %h want %h", w_dut, exp_vec());
        end
    endtask

    task automatic test_prescaler();
        for (int k = 1; k <= 35; k++) begin
            n_cmp++;
            if (o_ena !== (k % TD == 0)) begin
                n_err++;
                $display("FAIL prescaler_ena cyc %0d: got %b want %b", k, o_ena, k % TD == 0);
            end
            n_cmp++;
            if (w_dut !== exp_vec()) begin
                n_err++;
                $display("FAIL prescaler_vec cyc %0d: got %h want %h", k, w_dut, exp_vec());
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_time_set();
        int q[$];
        set_cur(0, 2, 40);
        q = {1, 3, 3, 3, 2};
        repeat (20) q.push_back(3);
        q.push_back(2);
        q.push_back(2);
        foreach (q[i]) begin
            tick(q[i] == 1, q[i] == 2, q[i] == 3);
            n_cmp++;
            if (o_ena !== 1'b0 || w_dut !== exp_vec()) begin
                n_err++;
                $display("FAIL time_set step %0d: got %h want %h", i, w_dut, exp_vec());
            end
        end
        n_cmp++;
        if ({o_load, o_hh_in, o_mm_in, o_ss_in} !== {1'b1, 8'h03, 8'h22, 8'h40}) begin
            n_err++;
            $display("FAIL time_load: got %b %h:%h:%h want 1 03:22:40",
                     o_load, o_hh_in, o_mm_in, o_ss_in);
        end
        for (int k = 1; k <= 12; k++) begin
            tick(0, 0, 0);
            n_cmp++;
            if (o_load !== 1'b0 || o_ena !== (k == TD)) begin
                n_err++;
                $display("FAIL post_load cyc %0d: load %b ena %b want 0 %b",
                         k, o_load, o_ena, k == TD);
            end
        end
    endtask

    task automatic test_wrap();
        set_cur(23, 59, 9);
        tick(1, 0, 0);
        tick(0, 0, 1);
        n_cmp++;
        if (o_hh_in !== 8'h00) begin
            n_err++;
            $display("FAIL wrap_hh: got %h want 00", o_hh_in);
        end
        tick(0, 1, 0);
        tick(0, 0, 1);
        n_cmp++;
        if ({o_hh_in, o_mm_in} !== {8'h00, 8'h00}) begin
            n_err++;
            $display("FAIL wrap_mm: got %h:%h want 00:00", o_hh_in, o_mm_in);
        end
        tick(0, 1, 0);
        tick(0, 0, 1);
        n_cmp++;
        if (o_ss_in !== 8'h10) begin
            n_err++;
            $display("FAIL carry_ss: got %h want 10", o_ss_in);
        end
        tick(1, 0, 0);
        n_cmp++;
        if (w_dut !== exp_vec() || o_edit_field !== 2'd0) begin
            n_err++;
            $display("FAIL wrap_abort: got %h want %h", w_dut, exp_vec());
        end
    endtask

    task automatic test_alarm_set();
        tick(0, 1, 0);
        n_cmp++;
        if ({o_setting_alarm, o_edit_field, o_hh_in, o_mm_in, o_ss_in} !==
            {1'b1, 2'd1, 24'h000000}) begin
            n_err++;
            $display("FAIL alarm_enter: got %b %0d %h:%h:%h want 1 1 00:00:00",
                     o_setting_alarm, o_edit_field, o_hh_in, o_mm_in, o_ss_in);
        end
        repeat (7) tick(0, 0, 1);
        tick(0, 1, 0);
        tick(0, 0, 1);
        tick(0, 1, 0);
        tick(0, 1, 0);
        n_cmp++;
        if ({o_put_alarm, o_load, o_hh_in, o_mm_in, o_ss_in} !==
            {2'b10, 8'h07, 8'h01, 8'h00}) begin
            n_err++;
            $display("FAIL alarm_put: got put %b load %b %h:%h:%h want 1 0 07:01:00",
                     o_put_alarm, o_load, o_hh_in, o_mm_in, o_ss_in);
        end
        tick(0, 0, 0);
        n_cmp++;
        if (o_put_alarm !== 1'b0 || w_dut !== exp_vec()) begin
            n_err++;
            $display("FAIL alarm_put_once: got %h want %h", w_dut, exp_vec());
        end
        tick(0, 1, 0);
        n_cmp++;
        if ({o_setting_alarm, o_hh_in, o_mm_in, o_ss_in} !== {1'b1, 24'h070100}) begin
            n_err++;
            $display("FAIL alarm_recall: got %b %h:%h:%h want 1 07:01:00",
                     o_setting_alarm, o_hh_in, o_mm_in, o_ss_in);
        end
        tick(1, 0, 0);
    endtask

    task automatic test_alarm_stop();
        int enas;
        bit got;
        i_alarm_in = 1'b1;
        tick(1, 0, 0);
        n_cmp++;
        if ({o_stop_alarm, o_edit_field, o_setting_alarm, o_load} !== 5'b10000) begin
            n_err++;
            $display("FAIL btn_stop: got stop %b field %0d set %b load %b want 1 0 0 0",
                     o_stop_alarm, o_edit_field, o_setting_alarm, o_load);
        end
        enas = 0;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            enas += int'(o_ena);
            tick(0, 0, 0);
            n_cmp++;
            if (o_stop_alarm !== m_stop) begin
                n_err++;
                $display("FAIL auto_stop_cyc %0d: got %b want %b", k, o_stop_alarm, m_stop);
            end
            if (o_stop_alarm === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got || enas != TO) begin
            n_err++;
            $display("FAIL auto_stop: seen %b after %0d ena want 1 after %0d", got, enas, TO);
        end
        i_alarm_in = 1'b0;
        tick(0, 0, 0);
    endtask

    task automatic test_reset_mid_edit();
        tick(1, 0, 0);
        tick(0, 1, 0);
        n_cmp++;
        if (o_edit_field !== 2'd2) begin
            n_err++;
            $display("FAIL pre_reset_field: got %0d want 2", o_edit_field);
        end
        do_reset(1);
        n_cmp++;
        if (w_dut !== 31'd0) begin
            n_err++;
            $display("FAIL reset_mid_edit: got %h want 0", w_dut);
        end
        tick(0, 0, 0);
        n_cmp++;
        if (o_load !== 1'b0 || w_dut !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_no_load: got %h want %h", w_dut, exp_vec());
        end
    endtask

    task automatic test_priority();
        set_cur(12, 34, 56);
        tick(1, 0, 0);
        tick(0, 1, 1);
        n_cmp++;
        if ({o_edit_field, o_hh_in} !== {2'd2, 8'h12}) begin
            n_err++;
            $display("FAIL ok_over_inc: got %0d %h want 2 12", o_edit_field, o_hh_in);
        end
        tick(0, 1, 0);
        tick(1, 0, 1);
        n_cmp++;
        if ({o_edit_field, o_load, o_ss_in} !== {2'd0, 1'b0, 8'h56}) begin
            n_err++;
            $display("FAIL mode_over_inc: got %0d %b %h want 0 0 56",
                     o_edit_field, o_load, o_ss_in);
        end
        tick(0, 0, 0);
        n_cmp++;
        if (o_load !== 1'b0 || w_dut !== exp_vec()) begin
            n_err++;
            $display("FAIL abort_no_load: got %h want %h", w_dut, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            set_cur($urandom_range(23), $urandom_range(59), $urandom_range(59));
            if ($urandom_range(24) == 0) i_alarm_in = ~i_alarm_in;
            tick($urandom_range(7) == 0, $urandom_range(4) == 0, $urandom_range(2) == 0);
            n_cmp++;
            if (w_dut !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h want %h", k, w_dut, exp_vec());
            end
        end
        i_alarm_in = 1'b0;
    endtask

    initial begin
        m_cyc = 0;
        m_base = 0;
        set_cur(0, 0, 0);
        test_reset();
        test_prescaler();
        test_time_set();
        test_wrap();
        test_alarm_set();
        test_alarm_stop();
        test_reset_mid_edit();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Front-end sequencer for the Digital_Clock datapath. Converts three debounced single-cycle button pulses into the clock's control strobes: BCD time/alarm values, a one-cycle load or put_alarm, and stop_alarm. Generates the 1 Hz ena tick from a prescaler and freezes it while the time is being edited. Sits between the button debouncers and Digital_Clock; hh_in/mm_in/ss_in/load/put_alarm/stop_alarm/ena wire straight across.

Parameters:
TICK_DIV, 100000000, clk cycles per ena pulse (sim uses 10).
ALARM_TIMEOUT, 60, ena ticks of continuous alarm before auto-stop.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_mode  in  1  debounced pulse: enter time-set / abort edit / stop alarm
btn_ok  in  1  debounced pulse: enter alarm-set / next field / stop alarm
btn_inc  in  1  debounced pulse: increment current field
cur_hh, cur_mm, cur_ss  in  8 each  live BCD time from Digital_Clock
alarm_in  in  1  alarm output of Digital_Clock
ena  out  1  one-cycle tick to Digital_Clock
hh_in, mm_in, ss_in  out  8 each  BCD edit registers
load  out  1  one-cycle time-load strobe
put_alarm  out  1  one-cycle alarm-program strobe
stop_alarm  out  1  one-cycle alarm-clear strobe
edit_field  out  2  0=none, 1=HH, 2=MM, 3=SS (display blink)
setting_alarm  out  1  high in A_* states

Behaviour:
- Reset: state RUN; ena, load, put_alarm, stop_alarm = 0; hh_in/mm_in/ss_in = 00; alarm shadow regs = 00:00:00; prescaler and timeout counters = 0; edit_field = 0; setting_alarm = 0. Reset mid-edit drops the edit with no strobe.
- Button priority in the same cycle: mode > ok > inc. Lower-priority pulses are discarded.
- Prescaler: counts 0..TICK_DIV-1. ena = 1 for the single cycle where count == TICK_DIV-1, then wraps to 0. In T_HH/T_MM/T_SS/T_LOAD the counter is held at 0 and ena = 0. A_* states do not affect the prescaler.
- States: RUN, T_HH, T_MM, T_SS, T_LOAD, A_HH, A_MM, A_SS, A_PUT.
- RUN + btn_mode (alarm_in = 0): go to T_HH; edit regs capture cur_hh/mm/ss on the same edge.
- RUN + btn_ok (alarm_in = 0): go to A_HH; edit regs load from the alarm shadow regs.
- RUN + alarm_in = 1: btn_mode or btn_ok is consumed. stop_alarm = 1 on the next cycle and the state stays RUN.
- Edit states, btn_inc: increments the field in BCD. HH wraps 23->00; MM/SS wrap 59->00. Low nibble 9 carries to the high nibble. Other fields are untouched.
- Edit states, btn_ok: HH->MM->SS. From T_SS go to T_LOAD; from A_SS go to A_PUT.
- Edit states, btn_mode: abort to RUN with no strobe. Alarm shadow regs are unchanged.
- T_LOAD: load = 1 for exactly one cycle (Moore, registered), then RUN. Prescaler restarts from 0, so the first ena comes TICK_DIV cycles later.
- A_PUT: put_alarm = 1 for exactly one cycle; shadow regs take the edit values; then RUN.
- Auto-stop: while alarm_in = 1, count ena ticks. When the count reaches ALARM_TIMEOUT, stop_alarm pulses one cycle. The counter clears whenever alarm_in = 0 or stop_alarm fires.
- Only one of load, put_alarm, stop_alarm may be high in any cycle. If auto-stop coincides with T_LOAD or A_PUT, stop_alarm is deferred one cycle.
- edit_field: 1/2/3 in the *_HH/*_MM/*_SS states, otherwise 0.
- hh_in/mm_in/ss_in are driven continuously from the edit regs. In RUN they hold their last value.

Decomposition:
- Package clock_ctrl_pkg holds the state enum, the edit_field codes, and BCD limits (HH_MAX = 8'h23, MS_MAX = 8'h59).
- One sub-module, tick_gen (prescaler with hold input, outputs ena). The BCD wrap-increment is a package function.

Test Plan:
- TICK_DIV = 10, release reset, no buttons -> ena high every 10th cycle, first at cycle 10 after reset deasserts; no strobes.
- cur = 00:02:40, btn_mode, btn_inc x3, ok, inc x20, ok, ok -> load high exactly 1 cycle with hh_in/mm_in/ss_in = 03:22:40; ena stays 0 from T_HH through T_LOAD.
- Wrap: in T_HH starting at 23, btn_inc -> 00. In T_MM starting at 59, btn_inc -> 00. 09 + inc -> 10 (not 0A).
- btn_ok, inc x7, ok, inc, ok, ok -> put_alarm pulses once with 07:01:00. A second btn_ok from RUN shows 07:01:00 on the outputs.
- alarm_in = 1, btn_mode -> stop_alarm pulses once, state stays RUN. With no button and ALARM_TIMEOUT = 3 -> stop_alarm on the 3rd ena.
- Reset asserted in T_MM -> next cycle RUN, all outputs 0, no load. btn_mode + btn_inc in the same cycle from T_SS -> abort to RUN, field unchanged.
